// File: rtl/lsu.sv
// RV32I load/store unit: one memory access at a time, 3 cycles minimum (accept, BUSY+ack, DONE), +1 per wait cycle.
// Stalls the core from accept through BUSY; aborts with bus_err after MAX_WAIT unacknowledged BUSY cycles.
module lsu #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        misalign,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  typedef enum logic [1:0] {END_STORE, END_LOAD, END_MISALIGN, END_BUS_ERR} end_t;

  state_t         state, next_state;
  end_t           end_q;
  logic [2:0]     f3_q;
  logic [1:0]     lo_q;
  logic [CW-1:0]  wait_cnt;
  logic           fault;
  logic           timeout;
  logic [3:0]     be_d;
  logic [31:0]    wdata_d;
  logic [7:0]     lane_b;
  logic [15:0]    lane_h;
  logic [31:0]    load_val;

  // Lane enables, store replication and fault detection from the request as presented.
  always_comb begin
    fault   = 1'b0;
    be_d    = 4'b0000;
    wdata_d = wdata;
    case (funct3[1:0])
      2'b00: begin
        be_d    = 4'b0001 << addr[1:0];
        wdata_d = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_d    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{wdata[15:0]}};
        fault   = addr[0];
      end
      2'b10: begin
        be_d  = 4'b1111;
        fault = |addr[1:0];
      end
      default: fault = 1'b1;
    endcase
    if (we ? funct3[2] : (funct3[2] & funct3[1]))
      fault = 1'b1;
  end

  assign timeout = (wait_cnt == WAIT_LAST);

  always_comb begin
    lane_b = mem_rdata[{lo_q, 3'b000} +: 8];
    lane_h = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  load_val = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_val = {24'd0, lane_b};
      3'b101:  load_val = {16'd0, lane_h};
      default: load_val = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (en) next_state = fault ? DONE : BUSY;
      BUSY:    if (mem_ack || timeout) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
      rdata     <= 32'd0;
      f3_q      <= 3'd0;
      lo_q      <= 2'd0;
      wait_cnt  <= '0;
      end_q     <= END_STORE;
    end else begin
      mem_req <= (next_state == BUSY);
      case (state)
        IDLE: if (en) begin
          if (fault) begin
            rdata <= 32'd0;
            end_q <= END_MISALIGN;
          end else begin
            mem_we    <= we;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_be    <= be_d;
            mem_wdata <= wdata_d;
            f3_q      <= funct3;
            lo_q      <= addr[1:0];
            wait_cnt  <= '0;
          end
        end
        BUSY: begin
          // An ack in the timeout cycle still counts as success.
          if (mem_ack) begin
            if (!mem_we) rdata <= load_val;
            end_q <= mem_we ? END_STORE : END_LOAD;
          end else if (timeout) begin
            rdata <= 32'd0;
            end_q <= END_BUS_ERR;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    stall    = ((state == IDLE) && en) || (state == BUSY);
    rvalid   = (state == DONE) && (end_q == END_LOAD);
    misalign = (state == DONE) && (end_q == END_MISALIGN);
    bus_err  = (state == DONE) && (end_q == END_BUS_ERR);
  end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed scenarios plus randomized accesses against a size/offset-arithmetic reference model.
module tb_lsu;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        reset, en, we, mem_ack, mem_req, mem_we, stall, rvalid, misalign, bus_err;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int total = 0;
  int bad = 0;
  logic [31:0] rdata_model = 32'd0;

  // Observations collected by do_access.
  int          o_stall, o_req, o_rv, o_mis, o_berr, o_both;
  bit          o_done, o_unstable, o_rv_done, o_mis_done, o_berr_done, o_idle_ok;
  logic        o_we;
  logic [31:0] o_addr, o_wdata, o_rdata;
  logic [3:0]  o_be;

  always #5 clk = ~clk;

  lsu #(.MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .en(en), .we(we), .funct3(funct3), .addr(addr), .wdata(wdata),
    .stall(stall), .rdata(rdata), .rvalid(rvalid), .misalign(misalign), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // Reference model: access size in bytes and offset arithmetic.
  function automatic int sz(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_fault(input logic w, input logic [2:0] f3, input logic [31:0] a);
    if (w && f3 > 3'd2) return 1'b1;
    if (!w && (f3 == 3'd3 || f3 >= 3'd6)) return 1'b1;
    return (int'(a[1:0]) % sz(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    return 4'(((1 << sz(f3)) - 1) << int'(a[1:0]));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz(f3)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * int'(a[1:0]));
    if (sz(f3) == 1) begin
      v = v & 32'h0000_00FF;
      if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz(f3) == 2) begin
      v = v & 32'h0000_FFFF;
      if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // Drives one instruction (en held until the end of DONE) and a memory that acks after ack_after wait cycles (-1: never).
  task automatic do_access(input logic a_we, input logic [2:0] a_f3, input logic [31:0] a_addr, input logic [31:0] a_wd,
                           input logic [31:0] a_rd, input int ack_after, input bit ack_in_done);
    int  busy;
    bit  first;
    o_stall = 0; o_req = 0; o_rv = 0; o_mis = 0; o_berr = 0; o_both = 0;
    o_done = 0; o_unstable = 0; o_rv_done = 0; o_mis_done = 0; o_berr_done = 0; o_idle_ok = 0;
    o_we = 1'b0; o_addr = '0; o_wdata = '0; o_rdata = '0; o_be = '0;
    busy = 0; first = 1;
    @(negedge clk);
    en = 1'b1; we = a_we; funct3 = a_f3; addr = a_addr; wdata = a_wd; mem_ack = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (stall) o_stall++;
      if (mem_req) o_req++;
      if (rvalid) o_rv++;
      if (misalign) o_mis++;
      if (bus_err) o_berr++;
      if (misalign && bus_err) o_both++;
      if (mem_req) begin
        if (first) begin
          o_we = mem_we; o_addr = mem_addr; o_be = mem_be; o_wdata = mem_wdata; first = 0;
        end else if ({o_we, o_addr, o_be, o_wdata} !== {mem_we, mem_addr, mem_be, mem_wdata}) begin
          o_unstable = 1;
        end
        mem_ack = (ack_after >= 0 && busy == ack_after);
        mem_rdata = mem_ack ? a_rd : $urandom;
        busy++;
      end else begin
        mem_ack = 1'b0;
        mem_rdata = $urandom;
      end
      if (!stall) begin
        o_done = 1; o_rdata = rdata; o_rv_done = rvalid; o_mis_done = misalign; o_berr_done = bus_err;
        if (ack_in_done) mem_ack = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    #1;
    o_idle_ok = !mem_req && !rvalid && !misalign && !bus_err;
    if (rvalid) o_rv++;
    if (misalign) o_mis++;
    if (bus_err) o_berr++;
    en = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%b want=0", mem_req); end
    total++;
    if ({mem_we, mem_be, mem_addr, mem_wdata, rdata, rvalid, misalign, bus_err, stall} !== '0) begin
      bad++; $display("FAIL reset_outputs we=%b be=%b addr=%h wd=%h rd=%h rv=%b mis=%b berr=%b stall=%b want all 0",
                      mem_we, mem_be, mem_addr, mem_wdata, rdata, rvalid, misalign, bus_err, stall);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_lb_sign();
    do_access(1'b0, 3'b000, 32'h0000_1003, 32'h5555_5555, 32'h8011_2233, 0, 0);
    total++; if (!o_done) begin bad++; $display("FAIL lb_done timed out"); end
    total++; if (o_be !== 4'b1000) begin bad++; $display("FAIL lb_be got=%b want=1000", o_be); end
    total++; if (o_addr !== 32'h0000_1000) begin bad++; $display("FAIL lb_addr got=%h want=00001000", o_addr); end
    total++; if (o_rdata !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_rdata got=%h want=ffffff80", o_rdata); end
    total++; if (o_rv_done !== 1'b1) begin bad++; $display("FAIL lb_rvalid got=%b want=1", o_rv_done); end
    total++; if (o_stall != 2) begin bad++; $display("FAIL lb_stall_cycles got=%0d want=2", o_stall); end
    total++; if (o_req != 1) begin bad++; $display("FAIL lb_req_cycles got=%0d want=1", o_req); end
    total++; if (!o_idle_ok) begin bad++; $display("FAIL lb_idle_after got=0 want=1"); end
    rdata_model = 32'hFFFF_FF80;
  endtask

  task automatic test_sh_wait();
    do_access(1'b1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 32'h1234_5678, 3, 0);
    total++; if (o_we !== 1'b1) begin bad++; $display("FAIL sh_we got=%b want=1", o_we); end
    total++; if (o_addr !== 32'h0000_2000) begin bad++; $display("FAIL sh_addr got=%h want=00002000", o_addr); end
    total++; if (o_be !== 4'b1100) begin bad++; $display("FAIL sh_be got=%b want=1100", o_be); end
    total++; if (o_wdata !== 32'hABCD_ABCD) begin bad++; $display("FAIL sh_wdata got=%h want=abcdabcd", o_wdata); end
    total++; if (o_unstable) begin bad++; $display("FAIL sh_stable got=unstable want=stable"); end
    total++; if (o_req != 4) begin bad++; $display("FAIL sh_req_cycles got=%0d want=4", o_req); end
    total++; if (o_rv != 0) begin bad++; $display("FAIL sh_rvalid got=%0d want=0", o_rv); end
    total++; if (o_stall != 5) begin bad++; $display("FAIL sh_stall_cycles got=%0d want=5", o_stall); end
    total++; if (o_rdata !== rdata_model) begin bad++; $display("FAIL sh_rdata_hold got=%h want=%h", o_rdata, rdata_model); end
  endtask

  task automatic test_lw_misalign();
    do_access(1'b0, 3'b010, 32'h0000_3001, 32'h0, 32'hCAFE_F00D, 0, 0);
    total++; if (o_req != 0) begin bad++; $display("FAIL mis_req_cycles got=%0d want=0", o_req); end
    total++; if (o_mis_done !== 1'b1) begin bad++; $display("FAIL mis_flag got=%b want=1", o_mis_done); end
    total++; if (o_mis != 1) begin bad++; $display("FAIL mis_pulse_len got=%0d want=1", o_mis); end
    total++; if (o_rdata !== 32'd0) begin bad++; $display("FAIL mis_rdata got=%h want=00000000", o_rdata); end
    total++; if (o_stall != 1) begin bad++; $display("FAIL mis_stall_cycles got=%0d want=1", o_stall); end
    total++; if (o_rv != 0 || o_berr != 0) begin bad++; $display("FAIL mis_other rv=%0d berr=%0d want 0 0", o_rv, o_berr); end
    rdata_model = 32'd0;
  endtask

  task automatic test_timeout();
    do_access(1'b0, 3'b010, 32'h0000_4000, 32'h0, 32'h1234_5678, 1, 0);
    total++; if (o_rdata !== 32'h1234_5678) begin bad++; $display("FAIL to_pre_lw got=%h want=12345678", o_rdata); end
    do_access(1'b0, 3'b101, 32'h0000_4000, 32'h0, 32'h0, -1, 0);
    total++; if (o_req != MW) begin bad++; $display("FAIL to_req_cycles got=%0d want=%0d", o_req, MW); end
    total++; if (o_berr_done !== 1'b1) begin bad++; $display("FAIL to_bus_err got=%b want=1", o_berr_done); end
    total++; if (o_berr != 1) begin bad++; $display("FAIL to_pulse_len got=%0d want=1", o_berr); end
    total++; if (o_both != 0 || o_mis != 0) begin bad++; $display("FAIL to_misalign both=%0d mis=%0d want 0 0", o_both, o_mis); end
    total++; if (o_rdata !== 32'd0) begin bad++; $display("FAIL to_rdata got=%h want=00000000", o_rdata); end
    total++; if (!o_idle_ok) begin bad++; $display("FAIL to_idle_after got=0 want=1"); end
    total++; if (o_stall != MW + 1) begin bad++; $display("FAIL to_stall_cycles got=%0d want=%0d", o_stall, MW + 1); end
    rdata_model = 32'd0;
  endtask

  task automatic test_reset_mid_busy();
    do_access(1'b0, 3'b000, 32'h0000_5001, 32'h0, 32'h0000_7F00, 0, 0);
    total++; if (o_rdata !== 32'h0000_007F) begin bad++; $display("FAIL rst_pre_lb got=%h want=0000007f", o_rdata); end
    @(negedge clk);
    en = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'h0000_5004; wdata = 32'h8765_4321; mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rst_busy2_req got=%b want=1", mem_req); end
    reset = 1'b1; en = 1'b0;
    #1;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_async_req got=%b want=0", mem_req); end
    total++;
    if ({mem_we, mem_be, mem_addr, mem_wdata, rdata, rvalid, misalign, bus_err, stall} !== '0) begin
      bad++; $display("FAIL rst_async_outputs we=%b be=%b addr=%h wd=%h rd=%h rv=%b mis=%b berr=%b stall=%b want all 0",
                      mem_we, mem_be, mem_addr, mem_wdata, rdata, rvalid, misalign, bus_err, stall);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    rdata_model = 32'd0;
    do_access(1'b0, 3'b010, 32'h0000_0000, 32'h0, 32'hDEAD_BEEF, 0, 0);
    total++; if (o_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rst_lw_rdata got=%h want=deadbeef", o_rdata); end
    total++; if (o_rv_done !== 1'b1) begin bad++; $display("FAIL rst_lw_rvalid got=%b want=1", o_rv_done); end
    total++; if (o_stall != 2 || o_req != 1) begin bad++; $display("FAIL rst_lw_latency stall=%0d req=%0d want 2 1", o_stall, o_req); end
    total++; if (o_be !== 4'b1111 || o_addr !== 32'd0) begin bad++; $display("FAIL rst_lw_lanes be=%b addr=%h want 1111 0", o_be, o_addr); end
    rdata_model = 32'hDEAD_BEEF;
  endtask

  task automatic test_ack_ignored();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      en = 1'b0; mem_ack = 1'b1; mem_rdata = $urandom;
      #1;
      total++;
      if (mem_req !== 1'b0 || rvalid !== 1'b0 || stall !== 1'b0 || rdata !== rdata_model) begin
        bad++; $display("FAIL idle_ack req=%b rv=%b stall=%b rd=%h want 0 0 0 %h", mem_req, rvalid, stall, rdata, rdata_model);
      end
    end
    @(negedge clk);
    mem_ack = 1'b0;
    do_access(1'b0, 3'b001, 32'h0000_6002, 32'h0, 32'h8001_0000, 0, 1);
    total++; if (o_rdata !== 32'hFFFF_8001) begin bad++; $display("FAIL done_ack_rdata got=%h want=ffff8001", o_rdata); end
    total++; if (!o_idle_ok) begin bad++; $display("FAIL done_ack_idle got=0 want=1"); end
    total++; if (o_rv != 1) begin bad++; $display("FAIL done_ack_rvalid_len got=%0d want=1", o_rv); end
    rdata_model = 32'hFFFF_8001;
  endtask

  task automatic test_random();
    logic        r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_addr, r_wd, r_rd;
    int          r_ack, exp_busy;
    bit          flt, tmo;
    for (int n = 0; n < 60; n++) begin
      r_we = 1'($urandom_range(0, 1)); r_f3 = 3'($urandom_range(0, 7));
      r_addr = $urandom; r_wd = $urandom; r_rd = $urandom;
      r_ack = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 3));
      flt = m_fault(r_we, r_f3, r_addr);
      tmo = !flt && r_ack < 0;
      exp_busy = flt ? 0 : (r_ack < 0 ? MW : r_ack + 1);
      do_access(r_we, r_f3, r_addr, r_wd, r_rd, r_ack, 0);
      if (flt || tmo) rdata_model = 32'd0;
      else if (!r_we) rdata_model = m_load(r_f3, r_addr, r_rd);
      total++; if (!o_done) begin bad++; $display("FAIL rnd_done n=%0d timed out", n); end
      total++; if (o_req != exp_busy) begin bad++; $display("FAIL rnd_req n=%0d got=%0d want=%0d", n, o_req, exp_busy); end
      total++; if (o_stall != exp_busy + 1) begin bad++; $display("FAIL rnd_stall n=%0d got=%0d want=%0d", n, o_stall, exp_busy + 1); end
      total++;
      if (o_mis != int'(flt) || o_berr != int'(tmo) || o_both != 0) begin
        bad++; $display("FAIL rnd_faults n=%0d mis=%0d berr=%0d both=%0d want %0d %0d 0", n, o_mis, o_berr, o_both, flt, tmo);
      end
      total++;
      if (o_rv != int'(!flt && !tmo && !r_we) || o_rv_done !== (!flt && !tmo && !r_we)) begin
        bad++; $display("FAIL rnd_rvalid n=%0d got=%0d want=%0d", n, o_rv, !flt && !tmo && !r_we);
      end
      total++; if (o_rdata !== rdata_model) begin bad++; $display("FAIL rnd_rdata n=%0d f3=%0d got=%h want=%h", n, r_f3, o_rdata, rdata_model); end
      if (!flt) begin
        total++;
        if (o_we !== r_we || o_addr !== {r_addr[31:2], 2'b00} || o_be !== m_be(r_f3, r_addr) || o_unstable) begin
          bad++; $display("FAIL rnd_bus n=%0d we=%b addr=%h be=%b unstable=%b want %b %h %b 0", n, o_we, o_addr, o_be, o_unstable,
                          r_we, {r_addr[31:2], 2'b00}, m_be(r_f3, r_addr));
        end
        if (r_we) begin
          total++; if (o_wdata !== m_wdata(r_f3, r_wd)) begin bad++; $display("FAIL rnd_wdata n=%0d got=%h want=%h", n, o_wdata, m_wdata(r_f3, r_wd)); end
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; en = 1'b0; we = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    test_reset();
    test_lb_sign();
    test_sh_wait();
    test_lw_misalign();
    test_timeout();
    test_reset_mid_busy();
    test_ack_ignored();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 255: the number of BUSY cycles without mem_ack after which the access aborts with bus_err.
REQ-002 SHALL have port clk  in  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports en  in  1  load/store instruction present (from decoder); we  in  1  1=store, 0=load; funct3  in  3  RV32I width/sign code.
REQ-005 SHALL have ports addr  in  32  effective address (ALU result); wdata  in  32  store data (rs2).
REQ-006 SHALL have ports stall  out  1  hold PC/regfile; rdata  out  32  extended load result; rvalid  out  1  load result valid.
REQ-007 SHALL have ports misalign  out  1  alignment/encoding fault pulse; bus_err  out  1  timeout fault pulse.
REQ-008 SHALL have ports mem_req  out  1; mem_we  out  1; mem_addr  out  32; mem_be  out  4; mem_wdata  out  32; mem_rdata  in  32; mem_ack  in  1.

Function
REQ-009 SHALL implement FSM states IDLE, BUSY and DONE; reset state is IDLE.
REQ-010 IDLE with en=1 and a legal, aligned access SHALL latch we, funct3, addr and wdata, and go to BUSY.
REQ-011 IDLE with en=1 and a fault SHALL go to DONE with misalign=1 for that DONE cycle, no bus transaction, and rdata=0.
REQ-012 A fault SHALL be: halfword with addr[0]=1; word with addr[1:0]!=0; load funct3 in {011,110,111}; store funct3 > 010.
REQ-013 stall SHALL equal (IDLE and en) or BUSY; it SHALL be 0 in DONE, so the CPU retires the instruction at the end of DONE.
REQ-014 mem_req SHALL be registered and equal 1 exactly while in BUSY.
REQ-015 mem_we, mem_addr, mem_be and mem_wdata SHALL stay stable throughout BUSY.
REQ-016 mem_addr SHALL be {addr[31:2],2'b00}.
REQ-017 mem_be SHALL be: byte 0001<<addr[1:0]; half 0011 (addr[1]=0) or 1100 (addr[1]=1); word 1111; the same lanes apply to loads.
REQ-018 mem_wdata SHALL replicate the data: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
REQ-019 BUSY with mem_ack=1 SHALL go to DONE; for a load, rdata SHALL be registered from the selected lane: LB/LH sign-extended, LBU/LHU zero-extended, LW unchanged.
REQ-020 rvalid SHALL be 1 only in a DONE cycle reached from a successful load.
REQ-021 rdata SHALL hold its value until the next load completes or faults.
REQ-022 A wait counter SHALL clear on entry to BUSY and increment each BUSY cycle without ack.
REQ-023 When the wait counter reaches MAX_WAIT, the block SHALL drop mem_req, go to DONE with bus_err=1 and rdata=0; an ack in that same cycle SHALL take priority (success).
REQ-024 DONE SHALL go to IDLE unconditionally and SHALL ignore en.
REQ-025 mem_ack SHALL be ignored in IDLE and DONE.
REQ-026 Minimum latency SHALL be 3 cycles (IDLE-accept, BUSY+ack, DONE), with stall high for 2 cycles; each BUSY wait cycle adds 1.
REQ-027 misalign and bus_err SHALL never be asserted together.
REQ-028 misalign and bus_err SHALL each last exactly one cycle.

Reset
REQ-029 Asserting reset SHALL immediately force state IDLE.
REQ-030 Asserting reset SHALL immediately clear the wait counter.
REQ-031 Asserting reset SHALL immediately force mem_req, mem_we, mem_be, mem_addr, mem_wdata, rdata, rvalid, misalign and bus_err to 0, including mid-BUSY.
REQ-032 After reset deassertion, the first accepted access SHALL behave identically to one after power-up.

Verification
REQ-033 The bench SHALL cover this case: LB, addr=0x1003, mem_rdata=0x80112233, ack in first BUSY cycle -> mem_be=1000, then in DONE rdata=0xFFFFFF80, rvalid=1, and stall high exactly 2 cycles.
REQ-034 The bench SHALL cover this case: SH, addr=0x2002, wdata=0x0000ABCD, ack after 3 wait cycles -> mem_we=1, mem_addr=0x2000, mem_be=1100, mem_wdata=0xABCDABCD, all stable over 4 BUSY cycles, and rvalid=0.
REQ-035 The bench SHALL cover this case: LW, addr=0x3001 -> no mem_req, misalign=1 in the cycle after en, rdata=0, and stall high 1 cycle.
REQ-036 The bench SHALL cover this case: LHU, addr=0x4000, ack never arrives, MAX_WAIT=4 -> mem_req high 4 cycles, then bus_err=1 for one cycle, and IDLE on the following cycle.
REQ-037 The bench SHALL cover this case: reset pulsed during the 2nd BUSY cycle of a store -> mem_req=0 asynchronously, all outputs 0, and a subsequent LW at 0x0 with mem_rdata=0xDEADBEEF returns 0xDEADBEEF.
REQ-038 The bench SHALL cover this case: mem_ack asserted in IDLE with en=0, and again during DONE -> no state change and no rvalid.
